text_console: RTL and testbench

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/text_console.sv | 172 +++++++++++++++++
 tb/tb_text_console.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// Text console writer: turns a stream of character codes into text-buffer
// cell writes, tracks the cursor, and blanks rows or the whole screen.
// Write/WAddr/WData are registered and are only ever high while the FSM is
// busy, so every write is issued on the edge that enters or stays in a
// writing state.
module text_console #(
   parameter int unsigned COLS     = 120,
   parameter int unsigned ROWS     = 60,
   parameter logic [9:0]  CLR_ATTR = 10'h00F
) (
   input  logic        clk50,
   input  logic        rst_n,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   input  logic [3:0]  char_fg,
   input  logic [3:0]  char_bg,
   input  logic [1:0]  char_bl,
   output logic        char_ready,
   output logic [12:0] WAddr,
   output logic [17:0] WData,
   output logic        Write,
   output logic [6:0]  cur_col,
   output logic [5:0]  cur_row,
   output logic        busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PUT     = 2'd1;
   localparam logic [1:0] CLR_ROW = 2'd2;
   localparam logic [1:0] CLR_ALL = 2'd3;

   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_FF = 8'h0C;
   localparam logic [7:0] CH_CR = 8'h0D;

   localparam logic [12:0] CELLS    = 13'(COLS * ROWS);
   localparam logic [12:0] ROW_STEP = 13'(COLS);
   localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
   localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
   localparam logic [17:0] BLANK    = {CLR_ATTR, 8'h20};

   logic [1:0]  state_q, state_d;
   logic [7:0]  code_q, code_d;        // command being executed in PUT
   logic [12:0] row_base_q, row_base_d; // cur_row * COLS, kept incrementally
   logic [12:0] cnt_q, cnt_d;          // clear progress, shared by both clears
   logic [6:0]  col_d;
   logic [5:0]  row_d;
   logic        write_d;
   logic [12:0] waddr_d;
   logic [17:0] wdata_d;
   logic        adv;

   assign char_ready = (state_q == IDLE);
   assign busy       = (state_q != IDLE);

   // Next-state, cursor update and write generation.
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      row_base_d = row_base_q;
      cnt_d      = cnt_q;
      col_d      = cur_col;
      row_d      = cur_row;
      write_d    = 1'b0;
      waddr_d    = WAddr;
      wdata_d    = WData;
      adv        = 1'b0;
      case (state_q)
         IDLE: begin
            if (char_valid) begin
               code_d = char_data;
               if (char_data == CH_FF) begin
                  state_d = CLR_ALL;
                  cnt_d   = 13'd0;
               end else begin
                  state_d = PUT;
                  if (!(char_data inside {CH_BS, CH_LF, CH_CR})) begin
                     write_d = 1'b1;
                     waddr_d = row_base_q + {6'd0, cur_col};
                     wdata_d = {char_bl, char_bg, char_fg, char_data};
                  end
               end
            end
         end
         PUT: begin
            state_d = IDLE;
            case (code_q)
               CH_LF: begin
                  col_d = 7'd0;
                  adv   = 1'b1;
               end
               CH_CR: col_d = 7'd0;
               CH_BS: if (cur_col != 7'd0) col_d = cur_col - 7'd1;
               default: begin
                  if (cur_col == LAST_COL) begin
                     col_d = 7'd0;
                     adv   = 1'b1;
                  end else begin
                     col_d = cur_col + 7'd1;
                  end
               end
            endcase
            // Moving to a new row always blanks it before more text lands.
            if (adv) begin
               state_d = CLR_ROW;
               cnt_d   = 13'd0;
               if (cur_row == LAST_ROW) begin
                  row_d      = 6'd0;
                  row_base_d = 13'd0;
               end else begin
                  row_d      = cur_row + 6'd1;
                  row_base_d = row_base_q + ROW_STEP;
               end
            end
         end
         CLR_ROW: begin
            if (cnt_q == ROW_STEP) begin
               state_d = IDLE;
            end else begin
               write_d = 1'b1;
               waddr_d = row_base_q + cnt_q;
               wdata_d = BLANK;
               cnt_d   = cnt_q + 13'd1;
            end
         end
         CLR_ALL: begin
            if (cnt_q == CELLS) begin
               state_d    = IDLE;
               col_d      = 7'd0;
               row_d      = 6'd0;
               row_base_d = 13'd0;
            end else begin
               write_d = 1'b1;
               waddr_d = cnt_q;
               wdata_d = BLANK;
               cnt_d   = cnt_q + 13'd1;
            end
         end
         default: begin
            state_d = CLR_ALL;
            cnt_d   = 13'd0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk50) begin
      if (!rst_n) begin
         state_q    <= CLR_ALL;
         code_q     <= 8'd0;
         row_base_q <= 13'd0;
         cnt_q      <= 13'd0;
         cur_col    <= 7'd0;
         cur_row    <= 6'd0;
         Write      <= 1'b0;
         WAddr      <= 13'd0;
         WData      <= 18'd0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         row_base_q <= row_base_d;
         cnt_q      <= cnt_d;
         cur_col    <= col_d;
         cur_row    <= row_d;
         Write      <= write_d;
         WAddr      <= waddr_d;
         WData      <= wdata_d;
      end
   end

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: a cursor model predicts every cell write into a
// scoreboard queue; a negedge monitor pops and compares each write.
module tb_text_console;

   localparam int COLS = 120;
   localparam int ROWS = 60;
   localparam logic [17:0] BLANK = 18'h00F20;

   logic        clk50 = 1'b0;
   logic        rst_n = 1'b0;
   logic        char_valid = 1'b0;
   logic [7:0]  char_data = 8'd0;
   logic [3:0]  char_fg = 4'd0;
   logic [3:0]  char_bg = 4'd0;
   logic [1:0]  char_bl = 2'd0;
   logic        char_ready;
   logic [12:0] WAddr;
   logic [17:0] WData;
   logic        Write;
   logic [6:0]  cur_col;
   logic [5:0]  cur_row;
   logic        busy;

   text_console #(
      .COLS     (COLS),
      .ROWS     (ROWS),
      .CLR_ATTR (10'h00F)
   ) dut (
      .clk50      (clk50),
      .rst_n      (rst_n),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_fg    (char_fg),
      .char_bg    (char_bg),
      .char_bl    (char_bl),
      .char_ready (char_ready),
      .WAddr      (WAddr),
      .WData      (WData),
      .Write      (Write),
      .cur_col    (cur_col),
      .cur_row    (cur_row),
      .busy       (busy)
   );

   always #5 clk50 = ~clk50;

   int          errors = 0;
   int          checks = 0;
   int          mcol = 0;
   int          mrow = 0;
   logic [30:0] sb[$];
   logic [30:0] mon_exp;
   logic [30:0] prev_out = '0;
   logic        edge_rst = 1'b0;

   // rst_n as seen by the most recent rising edge.
   always @(posedge clk50) edge_rst = rst_n;

   // Write monitor: each write must match the head of the scoreboard and
   // happen while busy; with Write low the bus must hold its last value.
   always @(negedge clk50) begin
      if (Write === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got WAddr=%0d WData=%h, required no write",
                     WAddr, WData);
         end else begin
            mon_exp = sb.pop_front();
            if ({WAddr, WData} !== mon_exp || char_ready !== 1'b0) begin
               errors++;
               $display("FAIL write_data: got WAddr=%0d WData=%h ready=%b, required WAddr=%0d WData=%h ready=0",
                        WAddr, WData, char_ready, mon_exp[30:18], mon_exp[17:0]);
            end
         end
      end else if (Write === 1'b0 && edge_rst === 1'b1) begin
         checks++;
         if ({WAddr, WData} !== prev_out) begin
            errors++;
            $display("FAIL hold_idle: got WAddr=%0d WData=%h, required WAddr=%0d WData=%h",
                     WAddr, WData, prev_out[30:18], prev_out[17:0]);
         end
      end
      prev_out = {WAddr, WData};
   end

   task automatic advance_row();
      mrow = (mrow + 1) % ROWS;
      for (int c = 0; c < COLS; c++) sb.push_back({13'(mrow * COLS + c), BLANK});
   endtask

   // Cursor model: predicts the writes and cursor effect of one character.
   task automatic model_char(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg,
                             input logic [1:0] bl);
      case (c)
         8'h0A: begin
            mcol = 0;
            advance_row();
         end
         8'h0D: mcol = 0;
         8'h08: if (mcol > 0) mcol--;
         8'h0C: begin
            for (int a = 0; a < COLS * ROWS; a++) sb.push_back({13'(a), BLANK});
            mcol = 0;
            mrow = 0;
         end
         default: begin
            sb.push_back({13'(mrow * COLS + mcol), bl, bg, fg, c});
            mcol++;
            if (mcol == COLS) begin
               mcol = 0;
               advance_row();
            end
         end
      endcase
   endtask

   task automatic wait_ready();
      bit ok = 0;
      for (int i = 0; i < 10000; i++) begin
         if (char_ready === 1'b1) begin
            ok = 1;
            break;
         end
         @(posedge clk50);
         #1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got char_ready=%b, required 1", char_ready);
      end
   endtask

   // One accepted transfer; afterwards inputs change to junk that must be ignored.
   task automatic send(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg,
                       input logic [1:0] bl);
      wait_ready();
      char_valid = 1'b1;
      char_data  = c;
      char_fg    = fg;
      char_bg    = bg;
      char_bl    = bl;
      model_char(c, fg, bg, bl);
      @(posedge clk50);
      #1;
      char_valid = 1'b0;
      char_data  = 8'h0C;
      char_fg    = 4'hE;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk50);
      #1;
      checks++;
      if (Write !== 1'b0 || WAddr !== 13'd0 || WData !== 18'd0) begin
         errors++;
         $display("FAIL reset_bus: got Write=%b WAddr=%0d WData=%h, required 0 0 0",
                  Write, WAddr, WData);
      end
      checks++;
      if (cur_col !== 7'd0 || cur_row !== 6'd0) begin
         errors++;
         $display("FAIL reset_cursor: got (%0d,%0d), required (0,0)", cur_col, cur_row);
      end
      checks++;
      if (char_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags: got ready=%b busy=%b, required ready=0 busy=1",
                  char_ready, busy);
      end
   endtask

   task automatic test_clear();
      model_char(8'h0C, 4'd0, 4'd0, 2'd0);
      rst_n = 1'b1;
      @(posedge clk50);
      #1;
      checks++;
      if (Write !== 1'b1 || WAddr !== 13'd0 || WData !== 18'h00F20) begin
         errors++;
         $display("FAIL clear_start: got Write=%b WAddr=%0d WData=%h, required 1 0 00f20",
                  Write, WAddr, WData);
      end
      wait_ready();
      checks++;
      if (sb.size() != 0 || cur_col !== 7'd0 || cur_row !== 6'd0) begin
         errors++;
         $display("FAIL clear_done: got pending=%0d cursor=(%0d,%0d), required 0 (0,0)",
                  sb.size(), cur_col, cur_row);
      end
   endtask

   task automatic test_put();
      send(8'h41, 4'd2, 4'd1, 2'd0);
      checks++;
      if (Write !== 1'b1 || WAddr !== 13'd0 || WData !== 18'h01241 || busy !== 1'b1) begin
         errors++;
         $display("FAIL put_write: got Write=%b WAddr=%0d WData=%h busy=%b, required 1 0 01241 1",
                  Write, WAddr, WData, busy);
      end
      wait_ready();
      checks++;
      if (sb.size() != 0 || cur_col !== 7'd1 || cur_row !== 6'd0) begin
         errors++;
         $display("FAIL put_cursor: got pending=%0d cursor=(%0d,%0d), required 0 (1,0)",
                  sb.size(), cur_col, cur_row);
      end
   endtask

   task automatic test_full_row();
      logic [7:0] c;
      send(8'h0D, 4'd0, 4'd0, 2'd0);
      for (int i = 0; i < COLS; i++) begin
         c = 8'(8'h21 + i % 90);
         send(c, 4'($urandom), 4'($urandom), 2'($urandom));
      end
      wait_ready();
      checks++;
      if (sb.size() != 0 || cur_col !== 7'd0 || cur_row !== 6'd1) begin
         errors++;
         $display("FAIL full_row: got pending=%0d cursor=(%0d,%0d), required 0 (0,1)",
                  sb.size(), cur_col, cur_row);
      end
   endtask

   task automatic test_lf_wrap();
      repeat (58) send(8'h0A, 4'd0, 4'd0, 2'd0);
      for (int i = 0; i < 5; i++) send(8'h61, 4'd7, 4'd0, 2'd1);
      wait_ready();
      checks++;
      if (sb.size() != 0 || cur_col !== 7'd5 || cur_row !== 6'd59) begin
         errors++;
         $display("FAIL lf_setup: got pending=%0d cursor=(%0d,%0d), required 0 (5,59)",
                  sb.size(), cur_col, cur_row);
      end
      send(8'h0A, 4'd0, 4'd0, 2'd0);
      wait_ready();
      checks++;
      if (sb.size() != 0 || cur_col !== 7'd0 || cur_row !== 6'd0) begin
         errors++;
         $display("FAIL lf_wrap: got pending=%0d cursor=(%0d,%0d), required 0 (0,0)",
                  sb.size(), cur_col, cur_row);
      end
      send(8'h0D, 4'd0, 4'd0, 2'd0);
      checks++;
      if (busy !== 1'b1 || Write !== 1'b0) begin
         errors++;
         $display("FAIL cr_busy: got busy=%b Write=%b, required busy=1 Write=0", busy, Write);
      end
      @(posedge clk50);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL cr_one_cycle: got busy=%b, required 0", busy);
      end
      send(8'h08, 4'd0, 4'd0, 2'd0);
      checks++;
      if (busy !== 1'b1 || Write !== 1'b0) begin
         errors++;
         $display("FAIL bs_busy: got busy=%b Write=%b, required busy=1 Write=0", busy, Write);
      end
      @(posedge clk50);
      #1;
      checks++;
      if (busy !== 1'b0 || sb.size() != 0 || cur_col !== 7'd0 || cur_row !== 6'd0) begin
         errors++;
         $display("FAIL bs_col0: got busy=%b pending=%0d cursor=(%0d,%0d), required 0 0 (0,0)",
                  busy, sb.size(), cur_col, cur_row);
      end
   endtask

   task automatic test_back_to_back();
      bit accepted = 0;
      wait_ready();
      char_valid = 1'b1;
      char_data  = 8'h0A;
      model_char(8'h0A, 4'd0, 4'd0, 2'd0);
      @(posedge clk50);
      #1;
      // Next character held valid across the whole row clear.
      char_data = 8'h5A;
      char_fg   = 4'd3;
      char_bg   = 4'd4;
      char_bl   = 2'd1;
      model_char(8'h5A, 4'd3, 4'd4, 2'd1);
      for (int i = 0; i < 400; i++) begin
         if (char_ready === 1'b1) begin
            @(posedge clk50);
            #1;
            accepted = 1;
            break;
         end
         @(posedge clk50);
         #1;
      end
      char_valid = 1'b0;
      checks++;
      if (!accepted) begin
         errors++;
         $display("FAIL b2b_accept: got accepted=0, required 1");
      end
      wait_ready();
      checks++;
      if (sb.size() != 0 || cur_col !== 7'd1 || cur_row !== 6'd1) begin
         errors++;
         $display("FAIL b2b_cursor: got pending=%0d cursor=(%0d,%0d), required 0 (1,1)",
                  sb.size(), cur_col, cur_row);
      end
   endtask

   task automatic test_reset_mid_clear();
      send(8'h0C, 4'd0, 4'd0, 2'd0);
      repeat (3000) @(posedge clk50);
      #1;
      rst_n = 1'b0;
      @(posedge clk50);
      #1;
      checks++;
      if (Write !== 1'b0 || WAddr !== 13'd0 || busy !== 1'b1 || char_ready !== 1'b0) begin
         errors++;
         $display("FAIL midreset_abort: got Write=%b WAddr=%0d busy=%b ready=%b, required 0 0 1 0",
                  Write, WAddr, busy, char_ready);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL midreset_partial: got pending=0, required pending>0");
      end
      sb.delete();
      @(posedge clk50);
      #1;
      model_char(8'h0C, 4'd0, 4'd0, 2'd0);
      rst_n = 1'b1;
      @(posedge clk50);
      #1;
      checks++;
      if (Write !== 1'b1 || WAddr !== 13'd0) begin
         errors++;
         $display("FAIL midreset_restart: got Write=%b WAddr=%0d, required 1 0", Write, WAddr);
      end
      wait_ready();
      checks++;
      if (sb.size() != 0 || cur_col !== 7'd0 || cur_row !== 6'd0) begin
         errors++;
         $display("FAIL midreset_done: got pending=%0d cursor=(%0d,%0d), required 0 (0,0)",
                  sb.size(), cur_col, cur_row);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_clear();
      test_put();
      test_full_row();
      test_lf_wrap();
      test_back_to_back();
      test_reset_mid_clear();
      repeat (3) @(posedge clk50);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
